mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported RAM between the instruction-fetch port and the data port of the request unit.
- Sequences each access through a small FSM and holds the address and data stable until the RAM signals ready.
- Returns one-cycle ihit/dhit pulses that stall or advance the pipeline.
- Data has priority; a starvation guard and a RAM timeout bound worst-case latency.

Parameters:
- ADDR_W, 32, address width in bits (word_t).
- DATA_W, 32, data width in bits (word_t).
- MAX_DSTREAK, 4, max consecutive data grants while iren is pending before instruction is forced.
- TIMEOUT, 15, max cycles in an access state without ram_ready before abort.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- iren  in  1  instruction read request, level, held until ihit.
- iaddr  in  ADDR_W  instruction address.
- ihit  out  1  one-cycle pulse: iload valid.
- iload  out  DATA_W  fetched instruction.
- dren  in  1  data read request.
- dwen  in  1  data write request (dren&dwen is illegal; dwen wins).
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dhit  out  1  one-cycle pulse: read data valid or write done.
- dload  out  DATA_W  read data.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_load  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM completes the current access this cycle.
- timeout_err  out  1  one-cycle pulse on access abort.

Behaviour:
- States: IDLE, IACC, DACC. All state and counters are registered; outputs are combinational from state plus latched request.
- Reset (async, RST=1): state=IDLE, dstreak=0, wait_cnt=0, latched addr/data/op=0. All outputs are 0 while in reset.
- IDLE, arbitration on each cycle:
  - If (dren|dwen) and not (iren & dstreak==MAX_DSTREAK): latch daddr, dstore and op; go to DACC.
  - Else if iren: latch iaddr; go to IACC.
  - Else stay in IDLE.
- IDLE drives no RAM strobes and asserts no hit. Minimum latency is request in cycle N, RAM strobe in N+1, hit no earlier than N+1.
- IACC: ram_ren=1, ram_addr=latched iaddr.
- DACC: ram_ren or ram_wen per latched op, ram_addr=latched daddr, ram_store=latched dstore.
- Completion: in IACC/DACC with ram_ready=1, assert ihit or dhit the same cycle and go to IDLE next cycle.
  - iload/dload = ram_load during the hit cycle, 0 otherwise.
  - Back-to-back accesses therefore have at least one IDLE cycle between them.
- Abort on dropped request: if the owning request deasserts before ram_ready, go to IDLE with no hit (a flushed fetch, for example).
- Abort on timeout: wait_cnt counts cycles in the access state and resets on entry.
  - If wait_cnt==TIMEOUT and ram_ready=0: pulse timeout_err, no hit, go to IDLE.
- dstreak:
  - Increments on each DACC completion while iren=1, saturating at MAX_DSTREAK.
  - Clears on IACC completion or whenever iren=0 in IDLE.
- Simultaneous events:
  - ram_ready together with request drop in the same cycle: completion wins (hit is asserted).
  - ram_ready on the timeout cycle: completion wins.
- Reset mid-access: strobes drop immediately (async), no hit is generated, and the FSM restarts in IDLE.
- Address and data changes on the iaddr/daddr inputs during an access are ignored; only the values latched at grant are used.

Test Plan:
- Reset then iren=1, iaddr=0x100, ram_ready one cycle after strobe, ram_load=0xDEADBEEF -> ram_ren in cycle 1, ihit+iload=0xDEADBEEF in cycle 2, then IDLE.
- iren and dren both 1 from the same cycle, daddr=0x200 -> DACC granted first, dhit, then IACC, then ihit; ram_addr sequence 0x200, 0x100.
- iren held, dren re-asserted for 6 consecutive accesses, MAX_DSTREAK=4 -> 4 data grants, then instruction grant, then data resumes.
- dwen=1, daddr=0x40, dstore=0x12345678, ram_ready after 3 cycles -> ram_wen held 3 cycles with stable addr/data, dhit=1, dload=0.
- ram_ready never asserted -> timeout_err pulses after TIMEOUT+1 cycles in DACC, no dhit, FSM back in IDLE.
- iren dropped mid-IACC, and separately RST pulsed mid-DACC -> no hit, strobes low, next request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data access.
// Data has priority, bounded by a starvation guard; a watchdog aborts stalled accesses.
//
//   state | meaning
//   IDLE  | no access in flight, arbitrate pending requests
//   IACC  | instruction read in flight, waiting for ram_ready
//   DACC  | data read/write in flight, waiting for ram_ready
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              timeout_err
);

  localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SK_W = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'(TIMEOUT);
  localparam logic [SK_W-1:0] SK_MAX  = SK_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t            state, state_n;
  logic [SK_W-1:0]   dstreak;
  logic [WC_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;

  logic d_req, force_i, wait_tc;
  logic grant_i, grant_d, streak_inc, streak_clr;

  assign d_req   = dren | dwen;
  assign force_i = iren && (dstreak == SK_MAX);
  // Watchdog runs down from TIMEOUT; terminal count is the abort cycle.
  assign wait_tc = (wait_cnt == '0);

  always_comb begin
    state_n     = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    streak_inc  = 1'b0;
    streak_clr  = 1'b0;
    ihit        = 1'b0;
    iload       = '0;
    dhit        = 1'b0;
    dload       = '0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_store   = '0;
    timeout_err = 1'b0;

    case (state)
      IDLE: begin
        if (!iren) streak_clr = 1'b1;
        if (d_req && !force_i) begin
          grant_d = 1'b1;
          state_n = DACC;
        end else if (iren) begin
          grant_i = 1'b1;
          state_n = IACC;
        end
      end

      IACC: begin
        ram_ren  = 1'b1;
        ram_addr = lat_addr;
        if (ram_ready) begin
          ihit       = 1'b1;
          iload      = ram_load;
          streak_clr = 1'b1;
          state_n    = IDLE;
        end else if (wait_tc) begin
          timeout_err = 1'b1;
          state_n     = IDLE;
        end else if (!iren) begin
          state_n = IDLE;
        end
      end

      DACC: begin
        ram_ren   = !lat_wr;
        ram_wen   = lat_wr;
        ram_addr  = lat_addr;
        ram_store = lat_data;
        if (ram_ready) begin
          dhit = 1'b1;
          if (!lat_wr) dload = ram_load;
          if (iren) streak_inc = 1'b1;
          state_n = IDLE;
        end else if (wait_tc) begin
          timeout_err = 1'b1;
          state_n     = IDLE;
        end else if (!d_req) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      dstreak  <= '0;
      wait_cnt <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
    end else begin
      state <= state_n;

      if (grant_d) begin
        lat_addr <= daddr;
        lat_data <= dstore;
        lat_wr   <= dwen;
      end else if (grant_i) begin
        lat_addr <= iaddr;
      end

      if (grant_d || grant_i) begin
        wait_cnt <= WC_LOAD;
      end else if (state != IDLE && !wait_tc) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (streak_clr) begin
        dstreak <= '0;
      end else if (streak_inc && dstreak != SK_MAX) begin
        dstreak <= dstreak + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;
  localparam int MAXS    = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iren, dren, dwen, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ram_load;
  logic        ihit, dhit, ram_ren, ram_wen, timeout_err;
  logic [31:0] iload, dload, ram_addr, ram_store;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iren(iren), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: the transaction currently owning the RAM, and the data-grant streak.
  bit          m_busy, m_isd, m_wr;
  logic [31:0] m_addr, m_data;
  int          m_age, m_streak;

  logic        s_ihit, s_dhit, s_ren, s_wen, s_terr;
  logic [31:0] s_iload, s_dload, s_addr, s_store;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic ie, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] ds, input logic rdy, input logic [31:0] rl);
    logic        e_ihit, e_dhit, e_ren, e_wen, e_terr;
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    RST = r; iren = ie; iaddr = ia; dren = dr; dwen = dw;
    daddr = da; dstore = ds; ram_ready = rdy; ram_load = rl;
    if (r) begin
      m_busy = 0; m_isd = 0; m_wr = 0; m_addr = '0; m_data = '0; m_age = 0; m_streak = 0;
    end
    #3;
    e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0; e_terr = 0;
    e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
    if (!r && m_busy) begin
      e_ren   = m_isd ? !m_wr : 1'b1;
      e_wen   = m_isd & m_wr;
      e_addr  = m_addr;
      e_store = m_isd ? m_data : 32'h0;
      if (rdy) begin
        if (m_isd) begin
          e_dhit  = 1;
          e_dload = m_wr ? 32'h0 : rl;
        end else begin
          e_ihit  = 1;
          e_iload = rl;
        end
      end else if (m_age == TIMEOUT) begin
        e_terr = 1;
      end
    end
    s_ihit = ihit; s_dhit = dhit; s_ren = ram_ren; s_wen = ram_wen; s_terr = timeout_err;
    s_iload = iload; s_dload = dload; s_addr = ram_addr; s_store = ram_store;
    chk("ihit", s_ihit, e_ihit);
    chk("iload", s_iload, e_iload);
    chk("dhit", s_dhit, e_dhit);
    chk("dload", s_dload, e_dload);
    chk("ram_ren", s_ren, e_ren);
    chk("ram_wen", s_wen, e_wen);
    chk("ram_addr", s_addr, e_addr);
    chk("ram_store", s_store, e_store);
    chk("timeout_err", s_terr, e_terr);
    if (!r) begin
      if (!m_busy) begin
        if (!ie) m_streak = 0;
        if ((dr || dw) && !(ie && m_streak == MAXS)) begin
          m_busy = 1; m_isd = 1; m_wr = dw; m_addr = da; m_data = ds; m_age = 0;
        end else if (ie) begin
          m_busy = 1; m_isd = 0; m_addr = ia; m_age = 0;
        end
      end else if (rdy) begin
        m_busy = 0;
        if (m_isd) begin
          if (ie) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        end else begin
          m_streak = 0;
        end
      end else if (m_age == TIMEOUT) begin
        m_busy = 0;
      end else if (m_isd ? !(dr || dw) : !ie) begin
        m_busy = 0;
      end else begin
        m_age++;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int exp_seq[7] = '{1, 1, 1, 1, 0, 1, 1};
  int n;

  initial begin
    RST = 1; iren = 0; dren = 0; dwen = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ram_load = 0;
    @(posedge CLK); #1;

    // Reset, then a single instruction fetch
    step(1, 1, 32'h100, 1, 0, 32'h200, 32'h1, 1, 32'hFFFF_FFFF);
    chk("rst_ren", s_ren, 0);
    chk("rst_ihit", s_ihit, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t1_c0_ren", s_ren, 0);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t1_c1_ren", s_ren, 1);
    chk("t1_c1_addr", s_addr, 32'h100);
    step(0, 1, 32'h100, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t1_c2_ihit", s_ihit, 1);
    chk("t1_c2_iload", s_iload, 32'hDEAD_BEEF);
    idle();
    chk("t1_c3_ren", s_ren, 0);

    // Simultaneous requests: data first, then instruction
    step(0, 1, 32'h100, 1, 0, 32'h200, 0, 0, 0);
    step(0, 1, 32'h100, 1, 0, 32'h200, 0, 1, 32'h11);
    chk("t2_daddr", s_addr, 32'h200);
    chk("t2_dhit", s_dhit, 1);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h100, 0, 0, 0, 0, 1, 32'h22);
    chk("t2_iaddr", s_addr, 32'h100);
    chk("t2_ihit", s_ihit, 1);

    // Starvation guard: four data grants, forced fetch, data resumes
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 32'h100, 1, 0, 32'h200 + k, 0, 0, 0);
      step(0, 1, 32'h100, 1, 0, 32'h200 + k, 0, 1, 32'hA0 + k);
      chk("t3_dhit", s_dhit, exp_seq[k]);
      chk("t3_ihit", s_ihit, (exp_seq[k] == 0) ? 1 : 0);
    end

    // Write with three-cycle RAM latency; inputs wander during the access
    idle();
    step(0, 0, 0, 0, 1, 32'h40, 32'h1234_5678, 0, 0);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 0, 0, 1, $urandom, $urandom, (j == 2), 32'hCAFE_F00D);
      chk("t4_wen", s_wen, 1);
      chk("t4_addr", s_addr, 32'h40);
      chk("t4_store", s_store, 32'h1234_5678);
      chk("t4_dhit", s_dhit, (j == 2) ? 1 : 0);
      chk("t4_dload", s_dload, 0);
    end
    idle();
    chk("t4_after_wen", s_wen, 0);

    // RAM never ready: watchdog abort
    step(0, 0, 0, 1, 0, 32'h80, 0, 0, 0);
    n = 0;
    for (int j = 0; j < 20; j++) begin
      step(0, 0, 0, 1, 0, 32'h80, 0, 0, 0);
      n++;
      chk("t5_no_dhit", s_dhit, 0);
      if (s_terr) break;
    end
    chk("t5_cycles", n, TIMEOUT + 1);
    idle();
    chk("t5_after_ren", s_ren, 0);
    chk("t5_after_terr", s_terr, 0);

    // Fetch flushed mid-access, then a normal fetch
    step(0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    chk("t6_ren", s_ren, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_drop_ihit", s_ihit, 0);
    idle();
    chk("t6_idle_ren", s_ren, 0);
    step(0, 1, 32'h310, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h310, 0, 0, 0, 0, 1, 32'h55);
    chk("t6_ihit", s_ihit, 1);
    chk("t6_iload", s_iload, 32'h55);
    chk("t6_addr", s_addr, 32'h310);
    idle();

    // Reset during a data access, then a normal read
    step(0, 0, 0, 1, 0, 32'h500, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h500, 0, 0, 0);
    chk("t7_ren", s_ren, 1);
    step(1, 0, 0, 1, 0, 32'h500, 0, 1, 32'h99);
    chk("t7_rst_ren", s_ren, 0);
    chk("t7_rst_dhit", s_dhit, 0);
    idle();
    step(0, 0, 0, 1, 0, 32'h540, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h540, 0, 1, 32'h77);
    chk("t7_dhit", s_dhit, 1);
    chk("t7_dload", s_dload, 32'h77);
    chk("t7_addr", s_addr, 32'h540);

    // Randomized soak, alternating responsive and sluggish RAM phases
    for (int c = 0; c < 3000; c++) begin
      logic r, ie, dr, dw, rdy;
      r   = ($urandom_range(0, 299) == 0);
      ie  = ($urandom_range(0, 3) != 0);
      dr  = ($urandom_range(0, 2) == 0);
      dw  = ($urandom_range(0, 3) == 0);
      if (((c / 500) % 2) == 1) rdy = ($urandom_range(0, 99) < 3);
      else                      rdy = ($urandom_range(0, 99) < 40);
      step(r, ie, $urandom, dr, dw, $urandom, $urandom, rdy, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
